// File: rtl/bcd_counter_n_pkg.sv
// rtl/bcd_counter_n_pkg.sv - shared BCD digit constants and digit validity helper
package bcd_counter_n_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // A nibble is a legal decimal digit only in the range 0..9.
  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// rtl/bcd_counter_n_digit.sv - single decade stage with up/down step and load
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         up,
  input  logic         ld,
  input  logic [3:0]   ld_val,
  output logic [3:0]   q,
  output logic         at_limit
);

  // The digit is about to roll over in the current direction.
  assign at_limit = up ? (q == BCD_MAX) : (q == BCD_MIN);

  // Load wins over stepping; clear arrives here as a load of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= ld_val;
    end else if (step) begin
      if (up) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - cascaded multi-digit BCD up/down counter with checked load
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      tc,
  output logic                      wrap,
  output logic                      load_err
);

  localparam int W = DIGIT_W * DIGITS;

  logic [DIGITS-1:0] digit_ok;
  logic [DIGITS-1:0] at_limit;
  logic [DIGITS-1:0] step;
  logic              load_ok;
  logic              ld_all;
  logic [W-1:0]      ld_data;
  logic              count_en;

  // Clear and an accepted load both become a digit load; a rejected load
  // still blocks counting for that cycle, so nothing changes.
  assign load_ok  = &digit_ok;
  assign ld_all   = clr | (load & load_ok);
  assign ld_data  = clr ? '0 : load_val;
  assign count_en = en & ~clr & ~load;

  // All digits sit at their limit: the next enabled step wraps the counter.
  assign tc = &at_limit;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit_ok[gi] = bcd_digit_valid(load_val[gi*DIGIT_W +: DIGIT_W]);

    // A digit moves only when every lower digit is rolling over.
    if (gi == 0) begin : g_lsd
      assign step[gi] = count_en;
    end else begin : g_upper
      assign step[gi] = count_en & (&at_limit[gi-1:0]);
    end

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .step     (step[gi]),
      .up       (up),
      .ld       (ld_all),
      .ld_val   (ld_data[gi*DIGIT_W +: DIGIT_W]),
      .q        (count[gi*DIGIT_W +: DIGIT_W]),
      .at_limit (at_limit[gi])
    );
  end

  // Single-cycle status pulses for the step or load sampled on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= count_en & tc;
      load_err <= ~clr & load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - scoreboard bench for bcd_counter_n against a decimal model
module tb_bcd_counter_n;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10000;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         load_err;

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    logic         err;
    logic         tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcount = 0;

  bcd_counter_n #(.DIGITS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Decimal value of a packed BCD word, with a flag for any illegal nibble.
  function automatic int bcd_val(input logic [W-1:0] v, output bit ok);
    int r = 0;
    int scale = 1;
    ok = 1'b1;
    for (int i = 0; i < D; i++) begin
      int nib = int'(v[4*i +: 4]);
      if (nib > 9) ok = 1'b0;
      r += nib * scale;
      scale *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r = '0;
    int x = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs and push the response the model predicts.
  task automatic apply(input logic c, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic u);
    exp_t x;
    bit   ok;
    int   v;
    @(negedge clk);
    clr = c; load = l; load_val = lv; en = e; up = u;
    x.wrap = 1'b0;
    x.err  = 1'b0;
    if (c) begin
      mcount = 0;
    end else if (l) begin
      v = bcd_val(lv, ok);
      if (ok) mcount = v;
      else    x.err = 1'b1;
    end else if (e) begin
      if (u) begin
        if (mcount == MOD - 1) x.wrap = 1'b1;
        mcount = (mcount + 1) % MOD;
      end else begin
        if (mcount == 0) x.wrap = 1'b1;
        mcount = (mcount + MOD - 1) % MOD;
      end
    end
    x.count = to_bcd(mcount);
    x.tc    = u ? (mcount == MOD - 1) : (mcount == 0);
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] lv);
    apply(1'b0, 1'b1, lv, 1'b0, 1'b1);
  endtask

  task automatic step_n(input int n, input logic u);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, '0, 1'b1, u);
  endtask

  // Monitor: the counter presents a new output after every edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count", 32'(count), 32'(x.count));
        chk("wrap", 32'(wrap), 32'(x.wrap));
        chk("load_err", 32'(load_err), 32'(x.err));
        chk("tc", 32'(tc), 32'(x.tc));
      end
    end
  end

  initial begin
    logic [W-1:0] lv;
    int           r;
    reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_load_err", 32'(load_err), 32'h0);
    chk("reset_tc_up", 32'(tc), 32'h0);
    up = 1'b0;
    #1;
    chk("reset_tc_down", 32'(tc), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    mcount = 0;

    // Count up from zero across the first carry.
    step_n(12, 1'b1);

    // Up wrap.
    do_load(16'h9998);
    step_n(3, 1'b1);

    // Down borrow and down wrap.
    do_load(16'h1000);
    step_n(2, 1'b0);
    do_load(16'h0001);
    step_n(3, 1'b0);

    // Rejected load leaves the count alone.
    do_load(16'h0042);
    do_load(16'h00A3);
    do_load(16'h0093);

    // Priority: clear over load over enable.
    do_load(16'h0057);
    apply(1'b1, 1'b1, 16'h0033, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 16'h0033, 1'b1, 1'b1);

    // Direction change flips tc without a step.
    do_load(16'h0000);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges with a load_err pulse pending.
    do_load(16'h1231);
    step_n(3, 1'b1);
    do_load(16'h12F4);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'h0);
    chk("async_wrap", 32'(wrap), 32'h0);
    chk("async_load_err", 32'(load_err), 32'h0);
    mcount = 0;
    clr = 1'b0; load = 1'b0; en = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Randomised traffic, biased toward the wrap boundaries.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        apply(1'b1, logic'($urandom_range(0, 1)), '0, logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)));
      end else if (r < 22) begin
        case ($urandom_range(0, 4))
          0: lv = 16'h9999;
          1: lv = 16'h0000;
          2: lv = 16'h9997;
          default: begin
            for (int i = 0; i < D; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0)
              lv[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
          end
        endcase
        apply(1'b0, 1'b1, lv, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      end else begin
        apply(1'b0, 1'b0, 16'($urandom), logic'($urandom_range(0, 4) != 0),
              logic'($urandom_range(0, 2) != 0));
      end
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0; clr = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
